// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO controller: register byte offsets,
// the register-select enum and small bus helpers.
package gpio_pkg;

    localparam logic [4:0] GPIO_DATA_IN  = 5'h00;
    localparam logic [4:0] GPIO_DATA_OUT = 5'h04;
    localparam logic [4:0] GPIO_DIR      = 5'h08;
    localparam logic [4:0] GPIO_IRQ_EN   = 5'h0C;
    localparam logic [4:0] GPIO_IRQ_RISE = 5'h10;
    localparam logic [4:0] GPIO_IRQ_FALL = 5'h14;
    localparam logic [4:0] GPIO_IRQ_STAT = 5'h18;

    typedef enum logic [2:0] {
        REG_DATA_IN  = 3'd0,
        REG_DATA_OUT = 3'd1,
        REG_DIR      = 3'd2,
        REG_IRQ_EN   = 3'd3,
        REG_IRQ_RISE = 3'd4,
        REG_IRQ_FALL = 3'd5,
        REG_IRQ_STAT = 3'd6,
        REG_RSVD     = 3'd7
    } gpio_reg_e;

    // Map the word-address bits onto a register select; the byte offset
    // table above is the single source of truth for the map.
    function automatic gpio_reg_e reg_decode(input logic [2:0] word);
        gpio_reg_e sel;
        case ({word, 2'b00})
            GPIO_DATA_IN:  sel = REG_DATA_IN;
            GPIO_DATA_OUT: sel = REG_DATA_OUT;
            GPIO_DIR:      sel = REG_DIR;
            GPIO_IRQ_EN:   sel = REG_IRQ_EN;
            GPIO_IRQ_RISE: sel = REG_IRQ_RISE;
            GPIO_IRQ_FALL: sel = REG_IRQ_FALL;
            GPIO_IRQ_STAT: sel = REG_IRQ_STAT;
            default:       sel = REG_RSVD;
        endcase
        return sel;
    endfunction

    // Expand the four byte-lane enables into a 32-bit bit mask.
    function automatic logic [31:0] lane_mask(input logic [3:0] sel);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) begin
            m[b*8 +: 8] = {8{sel[b]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// Pad input synchroniser followed by a one-cycle history flop; exposes the
// synchronised value and raw per-pin rising/falling edge flags.
module gpio_sync_edge #(
    parameter int N   = 32,
    parameter int STG = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] i_async,
    output logic [N-1:0] o_sync,
    output logic [N-1:0] o_rise,
    output logic [N-1:0] o_fall
);

    // Element 0 is the flop nearest the pads; element STG-1 is DATA_IN.
    logic [STG-1:0][N-1:0] r_sync;
    logic [N-1:0]          r_prev;

    // Shift pad samples through the synchroniser and remember last DATA_IN.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= '0;
            r_prev <= '0;
        end else begin
            r_sync <= {r_sync[STG-2:0], i_async};
            r_prev <= r_sync[STG-1];
        end
    end

    assign o_sync = r_sync[STG-1];
    assign o_rise = r_sync[STG-1] & ~r_prev;
    assign o_fall = ~r_sync[STG-1] & r_prev;

endmodule

// File: rtl/gpio_ctrl.sv
// Wishbone-mapped GPIO controller: register file, single-cycle ack bus
// slave, sticky edge status and level interrupt.
module gpio_ctrl
    import gpio_pkg::*;
#(
    parameter int N_GPIO   = 32,
    parameter int SYNC_STG = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wb_cyc_i,
    input  logic              wb_stb_i,
    input  logic              wb_we_i,
    input  logic [4:0]        wb_adr_i,
    input  logic [31:0]       wb_dat_i,
    input  logic [3:0]        wb_sel_i,
    output logic [31:0]       wb_dat_o,
    output logic              wb_ack_o,
    input  logic [N_GPIO-1:0] i_gpio,
    output logic [N_GPIO-1:0] o_gpio,
    output logic [N_GPIO-1:0] en_gpio,
    output logic              irq_o
);

    logic [N_GPIO-1:0] r_data_out;
    logic [N_GPIO-1:0] r_dir;
    logic [N_GPIO-1:0] r_irq_en;
    logic [N_GPIO-1:0] r_irq_rise;
    logic [N_GPIO-1:0] r_irq_fall;
    logic [N_GPIO-1:0] r_irq_stat;
    logic              r_ack;
    logic [31:0]       r_dat_o;
    logic              r_irq;

    logic              w_req;
    logic              w_wr;
    logic              w_rd;
    gpio_reg_e         w_reg;
    logic [N_GPIO-1:0] w_mask;
    logic [N_GPIO-1:0] w_dat;
    logic [N_GPIO-1:0] w_w1c;
    logic [N_GPIO-1:0] w_sync;
    logic [N_GPIO-1:0] w_rise;
    logic [N_GPIO-1:0] w_fall;
    logic [31:0]       w_rdata;
    logic              w_unused;

    gpio_sync_edge #(
        .N   (N_GPIO),
        .STG (SYNC_STG)
    ) u_sync_edge (
        .clk     (clk),
        .reset   (reset),
        .i_async (i_gpio),
        .o_sync  (w_sync),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

    // A new request is only seen while no ack is outstanding, which gives
    // the two-cycle cadence for back-to-back accesses.
    assign w_req  = wb_cyc_i & wb_stb_i & ~r_ack;
    assign w_wr   = w_req & wb_we_i;
    assign w_rd   = w_req & ~wb_we_i;
    assign w_reg  = reg_decode(wb_adr_i[4:2]);
    assign w_mask = N_GPIO'(lane_mask(wb_sel_i));
    assign w_dat  = wb_dat_i[N_GPIO-1:0];
    assign w_w1c  = (w_wr && (w_reg == REG_IRQ_STAT)) ? (w_dat & w_mask) : '0;

    // Byte address bits below the word boundary carry no meaning.
    assign w_unused = ^wb_adr_i[1:0];

    // Read data mux; upper bits beyond the pin count zero-extend.
    always_comb begin
        w_rdata = '0;
        case (w_reg)
            REG_DATA_IN:  w_rdata = 32'(w_sync);
            REG_DATA_OUT: w_rdata = 32'(r_data_out);
            REG_DIR:      w_rdata = 32'(r_dir);
            REG_IRQ_EN:   w_rdata = 32'(r_irq_en);
            REG_IRQ_RISE: w_rdata = 32'(r_irq_rise);
            REG_IRQ_FALL: w_rdata = 32'(r_irq_fall);
            REG_IRQ_STAT: w_rdata = 32'(r_irq_stat);
            default:      w_rdata = '0;
        endcase
    end

    // Acknowledge every request one edge later; read data is held only
    // for that ack cycle and is zero otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ack   <= 1'b0;
            r_dat_o <= '0;
        end else begin
            r_ack   <= w_req;
            r_dat_o <= w_rd ? w_rdata : '0;
        end
    end

    // Byte-lane writes to the plain RW registers, committed with the ack.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data_out <= '0;
            r_dir      <= '0;
            r_irq_en   <= '0;
            r_irq_rise <= '0;
            r_irq_fall <= '0;
        end else if (w_wr) begin
            case (w_reg)
                REG_DATA_OUT: r_data_out <= (r_data_out & ~w_mask) | (w_dat & w_mask);
                REG_DIR:      r_dir      <= (r_dir      & ~w_mask) | (w_dat & w_mask);
                REG_IRQ_EN:   r_irq_en   <= (r_irq_en   & ~w_mask) | (w_dat & w_mask);
                REG_IRQ_RISE: r_irq_rise <= (r_irq_rise & ~w_mask) | (w_dat & w_mask);
                REG_IRQ_FALL: r_irq_fall <= (r_irq_fall & ~w_mask) | (w_dat & w_mask);
                default: ;
            endcase
        end
    end

    // Sticky edge status (a new edge beats a same-cycle clear) and the
    // registered interrupt level one cycle behind it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_irq_stat <= '0;
            r_irq      <= 1'b0;
        end else begin
            r_irq_stat <= (r_irq_stat & ~w_w1c)
                        | (w_rise & r_irq_rise)
                        | (w_fall & r_irq_fall);
            r_irq      <= |(r_irq_stat & r_irq_en);
        end
    end

    assign wb_ack_o = r_ack;
    assign wb_dat_o = r_dat_o;
    assign o_gpio   = r_data_out;
    assign en_gpio  = r_dir;
    assign irq_o    = r_irq;

endmodule

// File: tb/tb_gpio_ctrl.sv
// Directed plus randomised bench for gpio_ctrl against a pin-history model.
module tb_gpio_ctrl;

    localparam logic [4:0] A_DIN  = 5'h00;
    localparam logic [4:0] A_OUT  = 5'h04;
    localparam logic [4:0] A_DIR  = 5'h08;
    localparam logic [4:0] A_EN   = 5'h0C;
    localparam logic [4:0] A_RISE = 5'h10;
    localparam logic [4:0] A_FALL = 5'h14;
    localparam logic [4:0] A_STAT = 5'h18;
    localparam logic [4:0] A_RSVD = 5'h1C;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_cyc_i, wb_stb_i, wb_we_i;
    logic [4:0]  wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic [31:0] i_gpio, o_gpio, en_gpio;
    logic        irq_o;

    gpio_ctrl #(.N_GPIO(32), .SYNC_STG(2)) dut (
        .clk(clk), .reset(reset),
        .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i),
        .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
        .i_gpio(i_gpio), .o_gpio(o_gpio), .en_gpio(en_gpio), .irq_o(irq_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Model: register contents plus the pad value seen at each clock edge.
    // DATA_IN is the pad sample from two edges back; the edge detector
    // compares it with the sample one edge older still.
    logic [31:0] m_out, m_dir, m_en, m_rise, m_fall, m_stat;
    logic        m_irq;
    logic [31:0] hist[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] lanes(input logic [3:0] sel);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) m[b*8 +: 8] = {8{sel[b]}};
        return m;
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] adr);
        case (adr[4:2])
            3'd0:    return hist[$-1];
            3'd1:    return m_out;
            3'd2:    return m_dir;
            3'd3:    return m_en;
            3'd4:    return m_rise;
            3'd5:    return m_fall;
            3'd6:    return m_stat;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_out = '0; m_dir = '0; m_en = '0; m_rise = '0; m_fall = '0;
        m_stat = '0; m_irq = 1'b0;
        hist = '{32'h0, 32'h0, 32'h0};
    endtask

    task automatic model_write(input logic [4:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        logic [31:0] m;
        m = lanes(sel);
        case (adr[4:2])
            3'd1: m_out  = (m_out  & ~m) | (dat & m);
            3'd2: m_dir  = (m_dir  & ~m) | (dat & m);
            3'd3: m_en   = (m_en   & ~m) | (dat & m);
            3'd4: m_rise = (m_rise & ~m) | (dat & m);
            3'd5: m_fall = (m_fall & ~m) | (dat & m);
            default: ;
        endcase
    endtask

    // One clock edge; w1c is the clear mask a write commits on this edge.
    task automatic cycle(input logic [31:0] w1c);
        logic [31:0] din, prv, nstat;
        logic        nirq;
        din   = hist[$-1];
        prv   = hist[$-2];
        nstat = (m_stat & ~w1c) | (din & ~prv & m_rise) | (~din & prv & m_fall);
        nirq  = |(m_stat & m_en);
        hist.push_back(i_gpio);
        if (hist.size() > 4) void'(hist.pop_front());
        @(posedge clk); #1;
        m_stat = nstat;
        m_irq  = nirq;
        check("irq_o", 32'(irq_o), 32'(m_irq));
    endtask

    task automatic reset_cycles(input int n);
        reset = 1'b1;
        repeat (n) begin @(posedge clk); #1; end
        model_reset();
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        reset = 1'b0;
    endtask

    task automatic wb_wr(input logic [4:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        logic [31:0] w1c;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
        wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = sel;
        w1c = (adr[4:2] == 3'd6) ? (dat & lanes(sel)) : 32'h0;
        cycle(w1c);
        check($sformatf("wr_ack@%h", adr), 32'(wb_ack_o), 32'd1);
        model_write(adr, dat, sel);
        cycle(32'h0);
        check($sformatf("wr_ack_drop@%h", adr), 32'(wb_ack_o), 32'd0);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    endtask

    task automatic wb_rd(input logic [4:0] adr, output logic [31:0] data);
        logic [31:0] exp;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0;
        wb_adr_i = adr; wb_sel_i = 4'hF;
        exp = m_read(adr);
        cycle(32'h0);
        check($sformatf("rd_ack@%h", adr), 32'(wb_ack_o), 32'd1);
        check($sformatf("rd_data@%h", adr), wb_dat_o, exp);
        data = wb_dat_o;
        cycle(32'h0);
        check($sformatf("rd_ack_drop@%h", adr), 32'(wb_ack_o), 32'd0);
        check($sformatf("rd_data_idle@%h", adr), wb_dat_o, 32'h0);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    endtask

    task automatic check_pins(input string tag);
        check({tag, "_o_gpio"}, o_gpio, m_out);
        check({tag, "_en_gpio"}, en_gpio, m_dir);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        reset = 1'b1;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0;
        i_gpio = 32'hFFFF_FFFF;
        model_reset();

        // Reset with all pads high
        reset_cycles(3);
        check("rst_o_gpio", o_gpio, 32'h0);
        check("rst_en_gpio", en_gpio, 32'h0);
        check("rst_irq", 32'(irq_o), 32'd0);
        check("rst_ack", 32'(wb_ack_o), 32'd0);
        check("rst_dat_o", wb_dat_o, 32'h0);
        cycle(32'h0);
        cycle(32'h0);
        wb_rd(A_DIN, d);
        check("t1_din", d, 32'hFFFF_FFFF);

        // Output drive
        wb_wr(A_DIR, 32'hFFFF_FFFF, 4'hF);
        wb_wr(A_OUT, 32'h5A5A_5A5A, 4'hF);
        check("t2_en", en_gpio, 32'hFFFF_FFFF);
        check("t2_out", o_gpio, 32'h5A5A_5A5A);

        // Byte lanes
        wb_wr(A_OUT, 32'h0, 4'hF);
        wb_wr(A_OUT, 32'hA5A5_A5A5, 4'b0101);
        wb_rd(A_OUT, d);
        check("t3_lanes", d, 32'h00A5_00A5);
        check_pins("t3");

        // Input synchroniser latency
        i_gpio = 32'h0;
        repeat (4) cycle(32'h0);
        i_gpio = 32'hA5A5_A5A5;
        cycle(32'h0);
        wb_rd(A_DIN, d);
        check("t4_din_after1", d, 32'h0);
        i_gpio = 32'h0;
        repeat (4) cycle(32'h0);
        i_gpio = 32'hA5A5_A5A5;
        cycle(32'h0);
        cycle(32'h0);
        wb_rd(A_DIN, d);
        check("t4_din_after2", d, 32'hA5A5_A5A5);

        // Rising-edge interrupt and W1C
        i_gpio = 32'h0;
        repeat (4) cycle(32'h0);
        wb_wr(A_RISE, 32'h1, 4'hF);
        wb_wr(A_EN, 32'h1, 4'hF);
        i_gpio = 32'h1;
        cycle(32'h0); check("t5_irq_e1", 32'(irq_o), 32'd0);
        cycle(32'h0); check("t5_irq_e2", 32'(irq_o), 32'd0);
        cycle(32'h0); check("t5_irq_e3", 32'(irq_o), 32'd0);
        cycle(32'h0); check("t5_irq_e4", 32'(irq_o), 32'd1);
        wb_rd(A_STAT, d);
        check("t5_stat_set", d, 32'h1);
        wb_wr(A_STAT, 32'h1, 4'hF);
        check("t5_irq_cleared", 32'(irq_o), 32'd0);
        wb_rd(A_STAT, d);
        check("t5_stat_clr", d, 32'h0);
        i_gpio = 32'h0;
        repeat (4) cycle(32'h0);
        i_gpio = 32'h1;
        cycle(32'h0);
        cycle(32'h0);
        wb_wr(A_STAT, 32'h1, 4'hF);
        wb_rd(A_STAT, d);
        check("t5_set_beats_w1c", d, 32'h1);
        wb_wr(A_STAT, 32'h1, 4'hF);
        wb_rd(A_STAT, d);
        check("t5_stat_clr2", d, 32'h0);

        // Reset during a request, then unmapped/RO writes
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
        wb_adr_i = A_OUT; wb_dat_i = 32'hFFFF_FFFF; wb_sel_i = 4'hF;
        reset_cycles(1);
        check("t6_rst_ack", 32'(wb_ack_o), 32'd0);
        check("t6_rst_out", o_gpio, 32'h0);
        cycle(32'h0);
        check("t6_no_late_ack", 32'(wb_ack_o), 32'd0);
        check("t6_out_after", o_gpio, 32'h0);
        wb_wr(A_DIR, 32'h0000_FFFF, 4'hF);
        wb_wr(A_OUT, 32'h1234_5678, 4'hF);
        wb_wr(A_RSVD, 32'hFFFF_FFFF, 4'hF);
        wb_wr(A_DIN, 32'hFFFF_FFFF, 4'hF);
        check("t6_out_kept", o_gpio, 32'h1234_5678);
        check("t6_dir_kept", en_gpio, 32'h0000_FFFF);
        wb_rd(A_RSVD, d);
        check("t6_rsvd_read", d, 32'h0);

        // Randomised pads and register traffic against the model
        wb_wr(A_RISE, $urandom, 4'hF);
        wb_wr(A_FALL, $urandom, 4'hF);
        wb_wr(A_EN, $urandom & $urandom, 4'hF);
        for (int i = 0; i < 400; i++) begin
            i_gpio = i_gpio ^ ($urandom & $urandom & $urandom);
            cycle(32'h0);
            if (i % 25 == 24) begin
                wb_rd(A_STAT, d);
                wb_rd(A_DIN, d);
                wb_wr(A_STAT, $urandom, 4'($urandom_range(0, 15)));
                wb_wr(A_OUT, $urandom, 4'($urandom_range(0, 15)));
                check_pins("rnd");
                if (i % 100 == 99) begin
                    wb_wr(A_EN, $urandom, 4'($urandom_range(0, 15)));
                    wb_wr(A_FALL, $urandom, 4'($urandom_range(0, 15)));
                end
            end
        end
        wb_rd(A_STAT, d);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
